// File: rtl/dspmac_seq_if.sv
// Bundle of the dspmac_seq control, operand-stream, MAC-command and result signals.
// master: the sequencer side. slave: the environment (requester, operand source, MAC, result sink).
// Ports: start/len/busy, op_valid/op_ready/op_a/op_b, mac_opcode/mac_a/mac_b/mac_result, res_valid/res_ready/res_data.
interface dspmac_seq_if #(
    parameter int LEN_W = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    busy;

    logic                    op_valid;
    logic                    op_ready;
    logic signed [15:0]      op_a;
    logic signed [15:0]      op_b;

    logic [1:0]              mac_opcode;
    logic signed [15:0]      mac_a;
    logic signed [15:0]      mac_b;
    logic signed [39:0]      mac_result;

    logic                    res_valid;
    logic                    res_ready;
    logic signed [39:0]      res_data;

    modport master (
        input  start, len, op_valid, op_a, op_b, mac_result, res_ready,
        output busy, op_ready, mac_opcode, mac_a, mac_b, res_valid, res_data
    );

    modport slave (
        output start, len, op_valid, op_a, op_b, mac_result, res_ready,
        input  busy, op_ready, mac_opcode, mac_a, mac_b, res_valid, res_data
    );
endinterface

// File: rtl/dspmac_seq.sv
// Dot-product job sequencer: feeds operand pairs to an external MAC and returns its accumulator.
// Latency: first opcode one cycle after acceptance; result MAC_LAT+1 cycles after the last opcode.
// Backpressure: op_ready only in FIRST/ACC; result held in DONE until res_ready.
// Ports: clk, rst (async active-high), bus (dspmac_seq_if.master); abort exists only when
// DSPMAC_SEQ_ABORT_EN is defined, in which case it cancels a job in FIRST, ACC or DRAIN.
module dspmac_seq #(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
`ifdef DSPMAC_SEQ_ABORT_EN
    input  logic             abort,
`endif
    dspmac_seq_if.master     bus
);
    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_MAC = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // Drain counter must hold 0..MAC_LAT; keep at least one bit when MAC_LAT is 0.
    localparam int            DW         = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FIRST = 3'd2,
        ACC   = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_inc;
    logic [DW-1:0]     dcnt;
    logic              accept;
    logic              abort_hit;

    assign accept  = bus.op_valid && bus.op_ready;
    assign cnt_inc = cnt + LEN_W'(1);

`ifdef DSPMAC_SEQ_ABORT_EN
    assign abort_hit = abort && (state inside {FIRST, ACC, DRAIN});
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start) state_nxt = (bus.len != '0) ? FIRST : CLEAR;
            CLEAR: state_nxt = DRAIN;
            // cnt is 0 in FIRST, so a len==1 job goes straight to DRAIN here.
            FIRST: if (accept) state_nxt = (cnt_inc == len_q) ? DRAIN : ACC;
            ACC:   if (accept && (cnt_inc == len_q)) state_nxt = DRAIN;
            DRAIN: if (dcnt == DRAIN_LAST) state_nxt = DONE;
            DONE:  if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            bus.busy       <= 1'b0;
            bus.op_ready   <= 1'b0;
            bus.res_valid  <= 1'b0;
            bus.res_data   <= '0;
            bus.mac_opcode <= OP_NOP;
            bus.mac_a      <= '0;
            bus.mac_b      <= '0;
            len_q          <= '0;
            cnt            <= '0;
            dcnt           <= '0;
        end else begin
            state        <= state_nxt;
            // Outputs registered from the next state so they line up with the state register.
            bus.busy     <= (state_nxt != IDLE);
            bus.op_ready <= (state_nxt == FIRST) || (state_nxt == ACC);

            // Every cycle without a command is a NOP; operand buses keep their last value.
            bus.mac_opcode <= OP_NOP;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q <= bus.len;
                        cnt   <= '0;
                        if (bus.len == '0) bus.mac_opcode <= OP_CLR;
                    end
                end
                FIRST, ACC: begin
                    if (accept && !abort_hit) begin
                        bus.mac_a      <= bus.op_a;
                        bus.mac_b      <= bus.op_b;
                        bus.mac_opcode <= (state == FIRST) ? OP_MUL : OP_MAC;
                        cnt            <= cnt_inc;
                    end
                end
                DONE: begin
                    if (bus.res_ready) bus.res_valid <= 1'b0;
                end
                default: ;
            endcase

            // Drain cycle counter restarts on every entry into DRAIN.
            if ((state == DRAIN) && (state_nxt == DRAIN)) dcnt <= dcnt + DW'(1);
            else                                          dcnt <= '0;

            if ((state == DRAIN) && (state_nxt == DONE)) begin
                bus.res_data  <= bus.mac_result;
                bus.res_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dspmac_seq.sv
module tb_dspmac_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef DSPMAC_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif
    int n_run  = 0;
    int n_fail = 0;

    dspmac_seq_if #(.LEN_W(8)) bus ();

    dspmac_seq #(.LEN_W(8), .MAC_LAT(1)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef DSPMAC_SEQ_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference MAC: opcode sampled on the edge, effect visible right after it (latency 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.mac_result <= '0;
        else case (bus.mac_opcode)
            2'b00: bus.mac_result <= '0;
            2'b01: bus.mac_result <= 40'(bus.mac_a * bus.mac_b);
            2'b10: bus.mac_result <= bus.mac_result + 40'(bus.mac_a * bus.mac_b);
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res();
        for (int i = 0; i < 20; i++) begin
            if (bus.res_valid) break;
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_run++; if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL reset_op_ready got %b want 0", bus.op_ready); end
        n_run++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got %b want 0", bus.res_valid); end
        n_run++; if (bus.res_data !== 40'sd0) begin n_fail++; $display("FAIL reset_res_data got %0d want 0", bus.res_data); end
        n_run++; if (bus.mac_opcode !== 2'b11) begin n_fail++; $display("FAIL reset_opcode got %b want 11", bus.mac_opcode); end
        n_run++; if (bus.mac_a !== 16'sd0 || bus.mac_b !== 16'sd0) begin n_fail++; $display("FAIL reset_mac_ab got %0d/%0d want 0/0", bus.mac_a, bus.mac_b); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_scale();
        bus.len = 8'd2; bus.start = 1'b1; bus.op_valid = 1'b1;
        bus.op_a = 16'sd32767; bus.op_b = 16'sd32767;
        tick();
        bus.start = 1'b0;
        n_run++; if (bus.op_ready !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL fs_first got rdy=%b busy=%b want 1/1", bus.op_ready, bus.busy); end
        tick();
        n_run++; if (bus.mac_opcode !== 2'b01) begin n_fail++; $display("FAIL fs_mul got %b want 01", bus.mac_opcode); end
        n_run++; if (bus.mac_a !== 16'sd32767) begin n_fail++; $display("FAIL fs_mac_a got %0d want 32767", bus.mac_a); end
        tick();
        bus.op_valid = 1'b0;
        n_run++; if (bus.mac_opcode !== 2'b10) begin n_fail++; $display("FAIL fs_mac got %b want 10", bus.mac_opcode); end
        tick();
        n_run++; if (bus.mac_opcode !== 2'b11 || bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL fs_drain got op=%b rdy=%b want 11/0", bus.mac_opcode, bus.op_ready); end
        wait_res();
        n_run++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL fs_res_valid timeout got %b want 1", bus.res_valid); end
        n_run++; if (bus.res_data !== 40'sd2147352578) begin n_fail++; $display("FAIL fs_res_data got %0d want 2147352578", bus.res_data); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        n_run++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL fs_release got vld=%b busy=%b want 0/0", bus.res_valid, bus.busy); end
    endtask

    task automatic test_len_zero();
        logic saw_ready;
        saw_ready = 1'b0;
        bus.len = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_run++; if (bus.mac_opcode !== 2'b00) begin n_fail++; $display("FAIL lz_clr got %b want 00", bus.mac_opcode); end
        n_run++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL lz_busy got %b want 1", bus.busy); end
        if (bus.op_ready) saw_ready = 1'b1;
        tick();
        n_run++; if (bus.mac_opcode !== 2'b11) begin n_fail++; $display("FAIL lz_clr_once got %b want 11", bus.mac_opcode); end
        for (int i = 0; i < 20 && !bus.res_valid; i++) begin
            if (bus.op_ready) saw_ready = 1'b1;
            tick();
        end
        n_run++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL lz_op_ready got %b want 0", saw_ready); end
        n_run++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL lz_res_valid timeout got %b want 1", bus.res_valid); end
        n_run++; if (bus.res_data !== 40'sd0) begin n_fail++; $display("FAIL lz_res_data got %0d want 0", bus.res_data); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_stall();
        bus.len = 8'd3; bus.start = 1'b1; bus.op_valid = 1'b1;
        bus.op_a = -16'sd32768; bus.op_b = -16'sd32768;
        tick();
        bus.start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            tick();
            bus.op_valid = 1'b0;
            n_run++; if (bus.mac_opcode !== ((p == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL st_pair%0d_op got %b want %b", p, bus.mac_opcode, (p == 0) ? 2'b01 : 2'b10); end
            if (p < 2) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    n_run++; if (bus.mac_opcode !== 2'b11 || bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL st_gap%0d_%0d got op=%b rdy=%b want 11/1", p, g, bus.mac_opcode, bus.op_ready); end
                end
                n_run++; if (bus.mac_a !== -16'sd32768) begin n_fail++; $display("FAIL st_hold_a got %0d want -32768", bus.mac_a); end
                bus.op_valid = 1'b1;
            end
        end
        wait_res();
        n_run++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL st_res_valid timeout got %b want 1", bus.res_valid); end
        n_run++; if (bus.res_data !== 40'sd3221225472) begin n_fail++; $display("FAIL st_res_data got %0d want 3221225472", bus.res_data); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic test_hold();
        bus.len = 8'd1; bus.start = 1'b1; bus.op_valid = 1'b1;
        bus.op_a = 16'sd5; bus.op_b = 16'sd7;
        tick();
        bus.start = 1'b0;
        tick();
        bus.op_valid = 1'b0;
        wait_res();
        n_run++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL hd_res_valid timeout got %b want 1", bus.res_valid); end
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            tick();
            n_run++; if (bus.res_valid !== 1'b1 || bus.res_data !== 40'sd35) begin n_fail++; $display("FAIL hd_stable%0d got vld=%b data=%0d want 1/35", i, bus.res_valid, bus.res_data); end
        end
        // start coinciding with res_ready in DONE must not launch a job
        bus.start = 1'b1; bus.res_ready = 1'b1;
        tick();
        bus.start = 1'b0; bus.res_ready = 1'b0;
        n_run++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL hd_release got busy=%b vld=%b want 0/0", bus.busy, bus.res_valid); end
        tick();
        n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL hd_start_ignored got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        logic saw_valid;
        saw_valid = 1'b0;
        bus.len = 8'd4; bus.start = 1'b1; bus.op_valid = 1'b1;
        bus.op_a = 16'sd9; bus.op_b = 16'sd9;
        tick();
        bus.start = 1'b0;
        tick();
        bus.op_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_run++; if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ctrl got busy=%b rdy=%b want 0/0", bus.busy, bus.op_ready); end
        n_run++; if (bus.mac_opcode !== 2'b11 || bus.mac_a !== 16'sd0 || bus.mac_b !== 16'sd0) begin n_fail++; $display("FAIL rm_mac got op=%b a=%0d b=%0d want 11/0/0", bus.mac_opcode, bus.mac_a, bus.mac_b); end
        n_run++; if (bus.res_valid !== 1'b0 || bus.res_data !== 40'sd0) begin n_fail++; $display("FAIL rm_res got vld=%b data=%0d want 0/0", bus.res_valid, bus.res_data); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.res_valid) saw_valid = 1'b1;
        end
        n_run++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_result got %b want 0", saw_valid); end
        bus.len = 8'd1; bus.start = 1'b1; bus.op_valid = 1'b1;
        bus.op_a = 16'sd2; bus.op_b = -16'sd3;
        tick();
        bus.start = 1'b0;
        tick();
        bus.op_valid = 1'b0;
        wait_res();
        n_run++; if (bus.res_valid !== 1'b1 || bus.res_data !== -40'sd6) begin n_fail++; $display("FAIL rm_new_job got vld=%b data=%0d want 1/-6", bus.res_valid, bus.res_data); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

`ifdef DSPMAC_SEQ_ABORT_EN
    task automatic test_abort();
        logic saw_valid;
        saw_valid = 1'b0;
        bus.len = 8'd3; bus.start = 1'b1; bus.op_valid = 1'b1;
        bus.op_a = 16'sd4; bus.op_b = 16'sd4;
        tick();
        bus.start = 1'b0;
        tick();
        n_run++; if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL ab_in_acc got rdy=%b want 1", bus.op_ready); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        bus.op_valid = 1'b0;
        n_run++; if (bus.busy !== 1'b0 || bus.op_ready !== 1'b0 || bus.mac_opcode !== 2'b11) begin n_fail++; $display("FAIL ab_idle got busy=%b rdy=%b op=%b want 0/0/11", bus.busy, bus.op_ready, bus.mac_opcode); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.res_valid) saw_valid = 1'b1;
        end
        n_run++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL ab_no_result got %b want 0", saw_valid); end
        bus.len = 8'd1; bus.start = 1'b1; bus.op_valid = 1'b1;
        bus.op_a = 16'sd1; bus.op_b = 16'sd1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.op_valid = 1'b0;
        wait_res();
        n_run++; if (bus.res_valid !== 1'b1 || bus.res_data !== 40'sd1) begin n_fail++; $display("FAIL ab_next_job got vld=%b data=%0d want 1/1", bus.res_valid, bus.res_data); end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.op_valid = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
        test_reset();
        test_full_scale();
        test_len_zero();
        test_stall();
        test_hold();
        test_reset_mid();
`ifdef DSPMAC_SEQ_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/dspmac_seq.md
DSPMAC_SEQ -- requirements
Module: dspmac_seq

Interface
REQ-001 Parameter: LEN_W, 8, width of the job-length field; maximum job is 2^LEN_W-1 operand pairs.
REQ-002 Parameter: MAC_LAT, 1, cycles from the MAC sampling an opcode to its effect appearing on mac_result.
REQ-003 Port: clk  in  1  single clock, all logic on rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: start  in  1  job request, sampled only in IDLE.
REQ-006 Port: len  in  LEN_W  number of operand pairs in the job, latched with start.
REQ-007 Port: busy  out  1  high in every state except IDLE.
REQ-008 Port: op_valid / op_ready  in / out  1 / 1  operand-pair stream handshake.
REQ-009 Port: op_a, op_b  in  16 each  signed operands.
REQ-010 Port: mac_opcode  out  2  MAC command: 00 CLR, 01 MUL, 10 MAC, 11 NOP.
REQ-011 Port: mac_a, mac_b  out  16 each  MAC operand buses.
REQ-012 Port: mac_result  in  40  signed MAC accumulator.
REQ-013 Port: res_valid / res_ready  out / in  1 / 1  result handshake.
REQ-014 Port: res_data  out  40  signed dot-product result.

Function
REQ-015 States SHALL be IDLE, CLEAR, FIRST, ACC, DRAIN and DONE.
REQ-016 IDLE + start with len!=0 SHALL latch len, clear the pair counter and go to FIRST; with len==0 it SHALL go to CLEAR.
REQ-017 CLEAR SHALL issue CLR for one cycle, then go to DRAIN.
REQ-018 op_ready SHALL be high only in FIRST and ACC; a pair is accepted when op_valid && op_ready.
REQ-019 An accepted pair SHALL be registered onto mac_a/mac_b with mac_opcode MUL in FIRST or MAC in ACC, visible on the cycle after acceptance.
REQ-020 mac_opcode SHALL be NOP in every cycle that does not carry CLR or an accepted pair; mac_a/mac_b SHALL hold their last values.
REQ-021 FIRST SHALL go to ACC after one acceptance; ACC SHALL go to DRAIN on the acceptance that brings the count to len; with len==1, FIRST SHALL go directly to DRAIN.
REQ-022 DRAIN SHALL wait MAC_LAT+1 cycles, then register mac_result into res_data, assert res_valid and go to DONE.
REQ-023 DONE SHALL hold res_valid and res_data stable until res_ready, then return to IDLE on the same edge.
REQ-024 start SHALL be ignored outside IDLE, including in the DONE cycle where res_ready is high.
REQ-025 op_valid SHALL be ignored outside FIRST/ACC; a stalled stream (op_valid low) SHALL keep the state and count, with NOP issued.
REQ-026 The block SHALL NOT saturate or modify res_data; it is the raw 40-bit MAC value.

Reset
REQ-027 rst SHALL asynchronously force: state IDLE, busy 0, op_ready 0, res_valid 0, res_data 0, mac_opcode 11, mac_a 0, mac_b 0, counter 0.
REQ-028 rst during any job SHALL abandon it; no res_valid SHALL follow for the abandoned job.

Configuration
REQ-029 With DSPMAC_SEQ_ABORT_EN defined, an input port abort (1 bit) SHALL exist.
REQ-030 With DSPMAC_SEQ_ABORT_EN, abort high in FIRST, ACC or DRAIN SHALL return to IDLE on the next edge: op_ready 0, mac_opcode NOP, no res_valid.
REQ-031 With DSPMAC_SEQ_ABORT_EN, abort SHALL be ignored in IDLE, CLEAR and DONE.
REQ-032 Without DSPMAC_SEQ_ABORT_EN, the abort port SHALL be absent and jobs SHALL be cancelled only by rst.

Verification
REQ-033 Job len=2, pairs (32767,32767) twice, op_valid held high -> opcodes MUL then MAC; res_data=2147352578.
REQ-034 Job len=0 -> single CLR issued, op_ready never high; res_valid with res_data=0.
REQ-035 Job len=3, pairs (-32768,-32768) with op_valid low for 2 cycles between pairs -> NOPs issued during the gaps; res_data=3221225472.
REQ-036 Result with res_ready low for 5 cycles -> res_valid and res_data stable throughout; start pulsed in that window is ignored; IDLE after res_ready.
REQ-037 rst asserted after the first pair of a len=4 job -> all outputs at reset values immediately; a new len=1 job with (2,-3) gives res_data=-6.
REQ-038 DSPMAC_SEQ_ABORT_EN build: abort in ACC -> IDLE next cycle, no res_valid; next job with len=1 and pair (1,1) gives res_data=1.
